request_unit: RTL and testbench

- Sequences one MIPS instruction at a time against a single-port memory system.
- Fetches an instruction and holds it stable in a register for the control unit to decode.
- Issues the data read or write that the decoded instruction requires, then pulses the PC enable.
- Sits between the memory interface (ihit/dhit) and the control unit's dread/dwrite/halt outputs; also keeps retired-instruction and stall-cycle counters.

---
 rtl/request_unit.sv | 108 ++++++++++
 tb/tb_request_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/request_unit.sv
// Instruction/data request sequencer: fetches one instruction, issues its data access,
// then strobes pc_en. Also counts retired instructions and memory stall cycles.
module request_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    input  logic             dhit,
    input  logic             dread,
    input  logic             dwrite,
    input  logic             halt_in,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      instr,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        DATA,
        HALT
    } state_t;

    state_t state, next_state;
    logic   wr_pend;
    logic   fetch_hit;
    logic   start_data;
    logic   retire;
    logic   stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            instr       <= '0;
            wr_pend     <= 1'b0;
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (fetch_hit)
                instr <= imemload;
            // A combined read+write request is treated as a store.
            if (start_data)
                wr_pend <= dwrite;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
            if (stall)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        halted     = 1'b0;
        fetch_hit  = 1'b0;
        start_data = 1'b0;
        retire     = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    fetch_hit  = 1'b1;
                    next_state = EXEC;
                end else begin
                    stall = 1'b1;
                end
            end
            EXEC: begin
                if (halt_in) begin
                    next_state = HALT;
                end else if (dread || dwrite) begin
                    start_data = 1'b1;
                    next_state = DATA;
                end else begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end
            end
            DATA: begin
                dmemWEN = wr_pend;
                dmemREN = !wr_pend;
                if (dhit) begin
                    retire     = 1'b1;
                    next_state = FETCH;
                end else begin
                    stall = 1'b1;
                end
            end
            HALT: halted = 1'b1;
            default: next_state = IDLE;
        endcase
        pc_en = retire;
    end

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: instruction-level transactions drive a small-counter and a
// full-width instance side by side; expectations come from per-transaction cycle budgets.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dread, dwrite, halt_in;
    logic [31:0] imemload;

    logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
    logic [31:0] instr;
    logic [3:0]  icnt4, scnt4;

    logic        imemREN_w, dmemREN_w, dmemWEN_w, pc_en_w, halted_w;
    logic [31:0] instr_w;
    logic [31:0] icnt32, scnt32;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned retired  = 0;
    int unsigned stalls   = 0;

    always #5 CLK = ~CLK;

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
        .dread(dread), .dwrite(dwrite), .halt_in(halt_in),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .instr(instr),
        .pc_en(pc_en), .halted(halted), .instr_count(icnt4), .stall_count(scnt4)
    );

    request_unit #(.CNT_W(32)) dut32 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
        .dread(dread), .dwrite(dwrite), .halt_in(halt_in),
        .imemREN(imemREN_w), .dmemREN(dmemREN_w), .dmemWEN(dmemWEN_w), .instr(instr_w),
        .pc_en(pc_en_w), .halted(halted_w), .instr_count(icnt32), .stall_count(scnt32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic i, input logic r, input logic w,
                           input logic p, input logic h);
        chk({tag, ".imemREN"}, imemREN, i);
        chk({tag, ".dmemREN"}, dmemREN, r);
        chk({tag, ".dmemWEN"}, dmemWEN, w);
        chk({tag, ".pc_en"},   pc_en,   p);
        chk({tag, ".halted"},  halted,  h);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".icnt4"},  icnt4,  retired % 16);
        chk({tag, ".scnt4"},  scnt4,  stalls % 16);
        chk({tag, ".icnt32"}, icnt32, retired);
        chk({tag, ".scnt32"}, scnt32, stalls);
        chk({tag, ".instr32"}, instr_w, instr);
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the DUT at the start of its first FETCH cycle.
    task automatic do_reset();
        nRST = 1'b0;
        ihit = 1'($urandom); dhit = 1'($urandom); imemload = $urandom;
        advance();
        nRST = 1'b1;
        ihit = 1'b0; dhit = 1'b0; dread = 1'b0; dwrite = 1'b0; halt_in = 1'b0;
        retired = 0;
        stalls  = 0;
        @(negedge CLK);
        chk_out("reset_idle", 0, 0, 0, 0, 0);
        chk("reset_instr", instr, 32'h0);
        chk_counts("reset");
        advance();
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 load+store (acts as store), 4 halt
    task automatic do_instr(input logic [31:0] word, input int kind, input int fw, input int dw);
        logic wr;
        wr = (kind == 2 || kind == 3);
        dread = 1'b0; dwrite = 1'b0; halt_in = 1'b0;
        for (int i = 0; i < fw; i++) begin
            ihit = 1'b0; dhit = 1'($urandom); imemload = $urandom;
            @(negedge CLK);
            chk_out("fetch_wait", 1, 0, 0, 0, 0);
            stalls++;
            advance();
        end
        ihit = 1'b1; imemload = word; dhit = 1'($urandom);
        @(negedge CLK);
        chk_out("fetch_hit", 1, 0, 0, 0, 0);
        advance();
        ihit = 1'($urandom); dhit = 1'($urandom); imemload = $urandom;
        halt_in = (kind == 4);
        dread   = (kind == 1 || kind == 3);
        dwrite  = (kind == 2 || kind == 3);
        @(negedge CLK);
        chk("exec_instr", instr, word);
        chk_out("exec", 0, 0, 0, kind == 0, 0);
        if (kind == 0) retired++;
        advance();
        if (kind >= 1 && kind <= 3) begin
            for (int i = 0; i < dw; i++) begin
                ihit = 1'($urandom); dhit = 1'b0;
                @(negedge CLK);
                chk_out("data_wait", 0, !wr, wr, 0, 0);
                chk("data_instr", instr, word);
                stalls++;
                advance();
            end
            ihit = 1'($urandom); dhit = 1'b1;
            @(negedge CLK);
            chk_out("data_hit", 0, !wr, wr, 1, 0);
            retired++;
            advance();
        end
        dread = 1'b0; dwrite = 1'b0;
        if (kind == 4) begin
            for (int i = 0; i < 20; i++) begin
                ihit = 1'($urandom); dhit = 1'($urandom); imemload = $urandom;
                halt_in = 1'($urandom); dread = 1'($urandom); dwrite = 1'($urandom);
                @(negedge CLK);
                chk_out("halt", 0, 0, 0, 0, 1);
                chk("halt_instr", instr, word);
                advance();
            end
            halt_in = 1'b0; dread = 1'b0; dwrite = 1'b0;
        end
        @(negedge CLK);
        chk_counts("after_instr");
        @(posedge CLK);
        #1;
        // The extra cycle above is only legal from HALT; other kinds re-enter via the caller.
    endtask

    // Variant used for everything that must return to FETCH with no idle gap.
    task automatic run(input logic [31:0] word, input int kind, input int fw, input int dw);
        logic wr;
        wr = (kind == 2 || kind == 3);
        dread = 1'b0; dwrite = 1'b0; halt_in = 1'b0;
        for (int i = 0; i < fw; i++) begin
            ihit = 1'b0; dhit = 1'($urandom); imemload = $urandom;
            @(negedge CLK);
            chk_out("fetch_wait", 1, 0, 0, 0, 0);
            stalls++;
            advance();
        end
        ihit = 1'b1; imemload = word; dhit = 1'($urandom);
        @(negedge CLK);
        chk_out("fetch_hit", 1, 0, 0, 0, 0);
        advance();
        ihit = 1'($urandom); dhit = 1'($urandom); imemload = $urandom;
        dread  = (kind == 1 || kind == 3);
        dwrite = (kind == 2 || kind == 3);
        @(negedge CLK);
        chk("exec_instr", instr, word);
        chk_out("exec", 0, 0, 0, kind == 0, 0);
        if (kind == 0) retired++;
        advance();
        if (kind != 0) begin
            for (int i = 0; i < dw; i++) begin
                ihit = 1'($urandom); dhit = 1'b0;
                @(negedge CLK);
                chk_out("data_wait", 0, !wr, wr, 0, 0);
                chk("data_instr", instr, word);
                stalls++;
                advance();
            end
            ihit = 1'($urandom); dhit = 1'b1;
            @(negedge CLK);
            chk_out("data_hit", 0, !wr, wr, 1, 0);
            retired++;
            advance();
        end
        dread = 1'b0; dwrite = 1'b0;
        ihit = 1'b0; dhit = 1'b0;
        chk_counts("after_instr");
    endtask

    initial begin
        nRST = 1'b0;
        ihit = 1'b0; dhit = 1'b0; dread = 1'b0; dwrite = 1'b0; halt_in = 1'b0;
        imemload = '0;
        @(posedge CLK);
        do_reset();

        run(32'h24010005, 0, 0, 0);          // addiu
        run(32'h8C220004, 1, 0, 3);          // lw, dhit three cycles late
        run(32'hAC220008, 3, 1, 2);          // sw with dread and dwrite both set

        for (int n = 0; n < 30; n++)
            run($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));

        // Reset while a load is waiting in the data phase.
        ihit = 1'b1; imemload = 32'h8C220004;
        advance();
        ihit = 1'b0; dread = 1'b1;
        advance();
        dhit = 1'b0;
        @(negedge CLK);
        chk_out("pre_reset_data", 0, 1, 0, 0, 0);
        @(posedge CLK);
        #1;
        do_reset();

        for (int n = 0; n < 16; n++)
            run($urandom, 0, 0, 0);
        chk("icnt4_wrap", icnt4, 4'h0);
        run(32'h24010005, 0, 17, 0);
        chk("scnt4_wrap", scnt4, 4'h1);

        do_reset();
        run(32'h8C220004, 1, 2, 1);
        do_instr(32'hFFFFFFFF, 4, 1, 0);
        chk_out("halt_sticky", 0, 0, 0, 0, 1);

        do_reset();
        run(32'h24010005, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
